cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 for the pipelined MIPS CPU; sits downstream of the system bridge and consumes its timer interrupt lines (IRQ0, IRQ1) plus one external interrupt.
- Holds SR, Cause, EPC and PRId.
- Arbitrates interrupts against exceptions raised by the M stage.
- Drives the pipeline-flush request and the return address for eret.

Parameters:
- PRID, 32'h0000_2021, constant value returned by PRId (reg 15).
- EXC_INT, 5'd0, ExcCode recorded for hardware interrupts.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- A1  input  5  mfc0 read register number.
- A2  input  5  mtc0 write register number.
- DIn  input  32  mtc0 write data.
- WE  input  1  mtc0 write enable (M stage, already qualified as valid).
- PC  input  32  PC of the instruction currently in M stage.
- BDIn  input  1  M-stage instruction sits in a branch delay slot.
- ExcCodeIn  input  5  exception code from M stage; 0 = no exception.
- HWInt  input  6  [0]=IRQ0 timer0, [1]=IRQ1 timer1, [2]=external, [5:3]=tie 0.
- EXLClr  input  1  eret committing in M stage.
- Req  output  1  take exception/interrupt this cycle (flush + jump to handler).
- EPCOut  output  32  current EPC register, used as the eret target.
- DOut  output  32  mfc0 read data.

Behaviour:
- Reset: all state clears on the first rising edge with reset=1.
  - SR.IM=0, SR.EXL=0, SR.IE=0.
  - Cause=0, EPC=0.
  - Outputs after reset: Req=0, EPCOut=0, DOut=0 for regs 12–14 and PRID for reg 15.
- SR (reg 12): stored bits IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause (reg 13):
  - BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - Read-only to mtc0; writes to reg 13 are ignored.
- EPC (reg 14): 32-bit, always word-aligned; bits [1:0] stored as 0.
- PRId (reg 15): read-only, returns PRID.
- DOut: combinational on A1; any other register number returns 0.
- IP update: IP <= HWInt every cycle, regardless of EXL or Req, so software sees the live pending lines one cycle late.
- Request logic (all combinational on the current inputs and state):
  - IntReq = |(HWInt & IM) & IE & ~EXL.
  - ExcReq = (ExcCodeIn != 0) & ~EXL.
  - Req = IntReq | ExcReq.
- Priority: interrupt over exception. When both are true, ExcCode <= EXC_INT and the exception is dropped; it re-raises when the instruction re-executes.
- On Req at a clock edge:
  - EXL <= 1.
  - Cause.BD <= BDIn.
  - ExcCode <= IntReq ? EXC_INT : ExcCodeIn.
  - EPC <= BDIn ? {PC[31:2],2'b00} - 4 : {PC[31:2],2'b00}.
- mtc0: when WE and no Req at that edge:
  - A2=12 writes IM/EXL/IE from DIn[15:10], DIn[1], DIn[0].
  - A2=14 writes EPC <= {DIn[31:2],2'b00}.
  - Other A2 values: no effect.
- eret: EXLClr and no Req → EXL <= 0 at the edge.
- Simultaneous events:
  - Req with WE: Req wins, write discarded.
  - Req with EXLClr: Req wins, EXL ends at 1.
  - WE to SR with EXLClr: EXLClr wins for EXL; IM and IE still take DIn.
  - reset with anything: reset wins.
- Nesting: while EXL=1, Req stays 0 for all interrupts and exceptions; Cause.IP keeps tracking.
- Latency:
  - Req and DOut are zero-latency (combinational).
  - All register updates are visible one cycle after the edge.
  - EPCOut reflects a same-cycle mtc0 EPC write only on the following cycle.
- Reset mid-operation: a pending Req or write in the same cycle is discarded; state returns to reset values.

Test Plan:
- Reset then read: reset=1 for 2 cycles, A1 swept 12..15 → DOut = 0, 0, 0, 32'h0000_2021; Req=0.
- Timer interrupt:
  - Setup: mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1); HWInt=6'b000001 at PC=32'h0000_3010, BDIn=0.
  - Response: Req=1 same cycle; next cycle EPC=32'h0000_3010, Cause=32'h0000_0400, EXL=1, Req=0.
- Masked/disabled interrupt:
  - SR=32'h0000_0400 (IE=0), HWInt=6'b000001 → Req=0, Cause.IP[10] reads 1.
  - Then EXLClr pulse → EXL stays 0; Req still 0.
- Delay-slot exception with priority:
  - Setup: ExcCodeIn=5'd12 at PC=32'h0000_3024 with BDIn=1, IE=0 → Req=1; next cycle EPC=32'h0000_3020, Cause=32'h8000_0030.
  - Repeat with IE=1, IM[11]=1, HWInt=6'b000010 → ExcCode=0, Cause=32'h8000_0800.
- Collisions:
  - WE=1, A2=14, DIn=32'h0000_5003 together with ExcCodeIn=4 → EPC=PC (write dropped).
  - After eret (EXLClr) with no Req, mtc0 EPC=32'h0000_5003 → EPCOut=32'h0000_5000.
- Nesting: with EXL=1, assert HWInt=6'b000111 and ExcCodeIn=10 → Req=0, EPC unchanged; after EXLClr, Req=1 immediately if IE=1.

Source files
------------

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_unit
// Brief    : MIPS coprocessor 0 (SR, Cause, EPC, PRId) with interrupt/exception
//            arbitration, flush request and eret return address.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_unit #(
    parameter logic [31:0] PRID    = 32'h0000_2021,
    parameter logic [4:0]  EXC_INT = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    localparam logic [4:0] c_reg_sr    = 5'd12;
    localparam logic [4:0] c_reg_cause = 5'd13;
    localparam logic [4:0] c_reg_epc   = 5'd14;
    localparam logic [4:0] c_reg_prid  = 5'd15;

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [29:0] r_epc;     // EPC[31:2]; the low bits are always zero

    logic        w_int_req;
    logic        w_exc_req;
    logic [29:0] w_epc_next;
    logic        w_unused;

    assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
    assign Req       = w_int_req | w_exc_req;

    // A delay-slot instruction restarts at its branch, one word earlier.
    assign w_epc_next = BDIn ? (PC[31:2] - 30'd1) : PC[31:2];
    assign w_unused   = ^PC[1:0];

    assign EPCOut = {r_epc, 2'b00};

    always_comb begin
        DOut = 32'h0;
        case (A1)
            c_reg_sr:    DOut = {16'h0, r_im, 8'h0, r_exl, r_ie};
            c_reg_cause: DOut = {r_bd, 15'h0, r_ip, 3'h0, r_exccode, 2'b00};
            c_reg_epc:   DOut = {r_epc, 2'b00};
            c_reg_prid:  DOut = PRID;
            default:     DOut = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= 6'h0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= 6'h0;
            r_exccode <= 5'h0;
            r_epc     <= 30'h0;
        end else begin
            r_ip <= HWInt;
            if (Req) begin
                r_exl     <= 1'b1;
                r_bd      <= BDIn;
                r_exccode <= w_int_req ? EXC_INT : ExcCodeIn;
                r_epc     <= w_epc_next;
            end else begin
                if (WE && (A2 == c_reg_sr)) begin
                    r_im  <= DIn[15:10];
                    r_exl <= DIn[1];
                    r_ie  <= DIn[0];
                end
                // eret overrides a simultaneous software write of EXL.
                if (EXLClr) begin
                    r_exl <= 1'b0;
                end
                if (WE && (A2 == c_reg_epc)) begin
                    r_epc <= DIn[31:2];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_unit
// Brief    : Self-checking bench for cp0_unit: register-level model plus
//            directed scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  A1, A2, ExcCodeIn;
    logic [31:0] DIn, PC;
    logic        WE, BDIn, EXLClr;
    logic [5:0]  HWInt;
    logic        Req;
    logic [31:0] EPCOut, DOut;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_unit dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .PC(PC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .Req(Req), .EPCOut(EPCOut), .DOut(DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole-register model: SR, Cause and EPC as 32-bit words.
    logic [31:0] m_sr, m_cause, m_epc;

    function automatic logic m_int();
        logic [5:0] im;
        im = m_sr[15:10];
        return (|(HWInt & im)) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_2021;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [31:0] sr, cause, epc;
        sr = m_sr; cause = m_cause; epc = m_epc;
        if (reset) begin
            sr = 0; cause = 0; epc = 0;
        end else begin
            cause = (cause & ~32'h0000_FC00) | ({26'h0, HWInt} << 10);
            if (m_req()) begin
                sr    = sr | 32'h2;
                cause = (cause & ~32'h8000_007C) | ({31'h0, BDIn} << 31)
                        | (m_int() ? 32'h0 : ({27'h0, ExcCodeIn} << 2));
                epc   = (PC & ~32'h3) - (BDIn ? 32'd4 : 32'd0);
            end else begin
                if (WE && A2 == 5'd12) sr = DIn & 32'h0000_FC03;
                if (EXLClr)            sr = sr & ~32'h2;
                if (WE && A2 == 5'd14) epc = DIn & ~32'h3;
            end
        end
        m_sr = sr; m_cause = cause; m_epc = epc;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_req",    {31'h0, Req}, {31'h0, m_req()});
        chk("model_epcout", EPCOut, m_epc);
        chk("model_dout",   DOut, m_read(A1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] exp);
        A1 = a;
        #1;
        chk(nm, DOut, exp);
    endtask

    task automatic req_is(input string nm, input logic exp);
        #1;
        chk(nm, {31'h0, Req}, {31'h0, exp});
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        WE = 1'b1; A2 = r; DIn = d;
        step();
        WE = 1'b0;
    endtask

    initial begin
        reset = 1'b1; A1 = 5'd12; A2 = 5'd0; DIn = 0; WE = 0; PC = 0;
        BDIn = 0; ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
        step(); step();
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, 32'h0000_2021);
        req_is("rst_req", 1'b0);
        reset = 1'b0;

        // Timer interrupt
        mtc0(5'd12, 32'h0000_0401);
        rd("sr_write", 5'd12, 32'h0000_0401);
        HWInt = 6'b000001; PC = 32'h0000_3010; BDIn = 0;
        req_is("tmr_req", 1'b1);
        step();
        rd("tmr_epc", 5'd14, 32'h0000_3010);
        rd("tmr_cause", 5'd13, 32'h0000_0400);
        rd("tmr_sr", 5'd12, 32'h0000_0403);
        req_is("tmr_req_exl", 1'b0);
        HWInt = 0; EXLClr = 1; step(); EXLClr = 0;
        rd("eret_sr", 5'd12, 32'h0000_0401);

        // Masked interrupt
        mtc0(5'd12, 32'h0000_0400);
        HWInt = 6'b000001;
        req_is("mask_req", 1'b0);
        step();
        rd("mask_ip", 5'd13, 32'h0000_0400);
        EXLClr = 1; step(); EXLClr = 0;
        rd("mask_exl", 5'd12, 32'h0000_0400);
        req_is("mask_req2", 1'b0);

        // Delay-slot exception
        HWInt = 0; ExcCodeIn = 5'd12; PC = 32'h0000_3024; BDIn = 1;
        req_is("bd_req", 1'b1);
        step();
        ExcCodeIn = 0; BDIn = 0;
        rd("bd_epc", 5'd14, 32'h0000_3020);
        rd("bd_cause", 5'd13, 32'h8000_0030);
        EXLClr = 1; step(); EXLClr = 0;
        mtc0(5'd12, 32'h0000_0801);
        HWInt = 6'b000010; ExcCodeIn = 5'd12; PC = 32'h0000_3024; BDIn = 1;
        req_is("prio_req", 1'b1);
        step();
        HWInt = 0; ExcCodeIn = 0; BDIn = 0;
        rd("prio_cause", 5'd13, 32'h8000_0800);
        rd("prio_epc", 5'd14, 32'h0000_3020);
        EXLClr = 1; step(); EXLClr = 0;

        // Collisions: exception beats mtc0 EPC
        WE = 1; A2 = 5'd14; DIn = 32'h0000_5003; ExcCodeIn = 5'd4; PC = 32'h0000_4000;
        step();
        WE = 0; ExcCodeIn = 0;
        rd("col_epc", 5'd14, 32'h0000_4000);
        rd("col_cause", 5'd13, 32'h0000_0010);
        EXLClr = 1; step(); EXLClr = 0;
        rd("col_sr", 5'd12, 32'h0000_0801);
        WE = 1; A2 = 5'd14; DIn = 32'h0000_5003;
        #1; chk("epcout_same_cycle", EPCOut, 32'h0000_4000);
        step(); WE = 0;
        chk("epcout_next", EPCOut, 32'h0000_5000);

        // Nesting
        ExcCodeIn = 5'd4; step();
        HWInt = 6'b000111; ExcCodeIn = 5'd10; PC = 32'h0000_6000;
        req_is("nest_req", 1'b0);
        step();
        rd("nest_epc", 5'd14, 32'h0000_4000);
        rd("nest_cause", 5'd13, 32'h0000_1C10);
        // SR write with eret: EXL cleared, IM/IE written
        WE = 1; A2 = 5'd12; DIn = 32'h0000_0803; EXLClr = 1;
        step(); WE = 0;
        rd("wesr_eret", 5'd12, 32'h0000_0801);
        req_is("post_eret_req", 1'b1);
        step(); EXLClr = 0;
        rd("req_eret_sr", 5'd12, 32'h0000_0803);
        rd("req_eret_cause", 5'd13, 32'h0000_1C00);
        rd("req_eret_epc", 5'd14, 32'h0000_6000);

        // Reset mid-operation
        HWInt = 0; ExcCodeIn = 0; EXLClr = 1; step(); EXLClr = 0;
        reset = 1; WE = 1; A2 = 5'd14; DIn = 32'h1234_5678; ExcCodeIn = 5'd8;
        step();
        reset = 0; WE = 0; ExcCodeIn = 0;
        rd("mid_rst_sr", 5'd12, 32'h0);
        rd("mid_rst_epc", 5'd14, 32'h0);
        rd("mid_rst_cause", 5'd13, 32'h0);
        rd("unmapped", 5'd3, 32'h0);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
